// File: rtl/button_event_gen.sv
// -----------------------------------------------------------------------------
// button_event_gen
// Turns the debounced push-button level into single-cycle event strobes:
// press, release, long-press, auto-repeat and (optionally) double-click.
// Runs on the same slow clock as the debounce stage; every output is a
// register, so each strobe appears one cycle after the sample that caused it.
//
// Optional feature macro: BUTTON_EVENT_DOUBLE_CLICK_EN
//   defined   : a short press followed by a new press within DBL_WINDOW
//               samples of its release raises double_pulse with press_pulse.
//   undefined : no gap state or gap counter, double_pulse is constant 0.
//
// Parameters:
//   CNT_WIDTH     width of the hold / repeat / gap counters
//   LONG_CYCLES   high samples (press sample included) before long_pulse
//   REPEAT_CYCLES sample period of repeat_pulse after long_pulse
//   DBL_WINDOW    max release-to-press distance for a double click
//
// Ports:
//   clk           clock (debounce-stage domain)
//   rst_n         synchronous reset, active-low
//   pb_debounced  debounced button level, 1 = pressed
//   press_pulse   one-cycle strobe on press
//   release_pulse one-cycle strobe on release
//   long_pulse    one-cycle strobe at the long-press threshold
//   repeat_pulse  one-cycle strobe every REPEAT_CYCLES samples after long
//   held          level, 1 while the button is registered as pressed
//   double_pulse  one-cycle strobe on the second press of a double click
// -----------------------------------------------------------------------------
module button_event_gen #(
   parameter int CNT_WIDTH     = 8,
   parameter int LONG_CYCLES   = 100,
   parameter int REPEAT_CYCLES = 25,
   parameter int DBL_WINDOW    = 30
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pb_debounced,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse,
   output logic repeat_pulse,
   output logic held,
   output logic double_pulse
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] LONG_LIM = CNT_WIDTH'(LONG_CYCLES);
   localparam logic [CNT_WIDTH-1:0] REP_LIM  = CNT_WIDTH'(REPEAT_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_PRESSED   = 2'd1,
      S_LONG_HELD = 2'd2
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
      ,
      S_GAP       = 2'd3
`endif
   } state_t;

   // Counters stop at all-ones instead of wrapping back to zero.
   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      if (v == CNT_MAX) begin
         sat_inc = v;
      end else begin
         sat_inc = v + CNT_ONE;
      end
   endfunction

   state_t                 r_state;
   logic                   r_pb_prev;
   logic [CNT_WIDTH-1:0]   r_hold_cnt;
   logic [CNT_WIDTH-1:0]   r_rep_cnt;
   logic                   r_press;
   logic                   r_release;
   logic                   r_long;
   logic                   r_repeat;
   logic                   r_held;
   logic                   r_double;

   logic                   w_rise;
   logic                   w_fall;
   logic [CNT_WIDTH-1:0]   w_hold_inc;
   logic [CNT_WIDTH-1:0]   w_rep_inc;

   // r_pb_prev is cleared by reset, so a button held through reset reads as a rising edge.
   assign w_rise     = pb_debounced & ~r_pb_prev;
   assign w_fall     = ~pb_debounced & r_pb_prev;
   assign w_hold_inc = sat_inc(r_hold_cnt);
   assign w_rep_inc  = sat_inc(r_rep_cnt);

`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
   localparam logic [CNT_WIDTH-1:0] DBL_LIM = CNT_WIDTH'(DBL_WINDOW);

   logic [CNT_WIDTH-1:0]   r_gap_cnt;
   logic                   r_dbl_arm;   // current press started from IDLE, so its release may lead to a double
   logic [CNT_WIDTH-1:0]   w_gap_inc;

   assign w_gap_inc = sat_inc(r_gap_cnt);
`else
   // The window has no meaning without the gap state; the reference keeps one parameter list for both builds.
   logic                   w_unused_dbl;
   assign w_unused_dbl = (DBL_WINDOW == 0);
`endif

   // Event FSM: state, counters and all registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_pb_prev  <= 1'b0;
         r_hold_cnt <= CNT_ZERO;
         r_rep_cnt  <= CNT_ZERO;
         r_press    <= 1'b0;
         r_release  <= 1'b0;
         r_long     <= 1'b0;
         r_repeat   <= 1'b0;
         r_held     <= 1'b0;
         r_double   <= 1'b0;
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
         r_gap_cnt  <= CNT_ZERO;
         r_dbl_arm  <= 1'b0;
`endif
      end else begin
         r_pb_prev <= pb_debounced;
         r_press   <= 1'b0;
         r_release <= 1'b0;
         r_long    <= 1'b0;
         r_repeat  <= 1'b0;
         r_double  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_rise) begin
                  r_press    <= 1'b1;
                  r_hold_cnt <= CNT_ONE;
                  r_held     <= 1'b1;
                  r_state    <= S_PRESSED;
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
                  r_dbl_arm  <= 1'b1;
`endif
               end else begin
                  r_held     <= 1'b0;
               end
            end
            S_PRESSED: begin
               // A release wins over a threshold that would be reached on the same sample.
               if (w_fall) begin
                  r_release <= 1'b1;
                  r_held    <= 1'b0;
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
                  r_gap_cnt <= CNT_ZERO;
                  if (DBL_WINDOW > 0) begin
                     r_state <= S_GAP;
                  end else begin
                     r_state <= S_IDLE;
                  end
`else
                  r_state   <= S_IDLE;
`endif
               end else begin
                  r_hold_cnt <= w_hold_inc;
                  if (w_hold_inc == LONG_LIM) begin
                     r_long    <= 1'b1;
                     r_rep_cnt <= CNT_ZERO;
                     r_state   <= S_LONG_HELD;
                  end else begin
                     r_state   <= S_PRESSED;
                  end
               end
            end
            S_LONG_HELD: begin
               // A long press never opens a double-click window.
               if (w_fall) begin
                  r_release <= 1'b1;
                  r_held    <= 1'b0;
                  r_state   <= S_IDLE;
               end else if (w_rep_inc == REP_LIM) begin
                  r_repeat  <= 1'b1;
                  r_rep_cnt <= CNT_ZERO;
               end else begin
                  r_rep_cnt <= w_rep_inc;
               end
            end
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
            S_GAP: begin
               // Any press here is within the window; it only counts as a double if
               // the press before it came from IDLE, so triple clicks give one double.
               if (w_rise) begin
                  r_press    <= 1'b1;
                  r_double   <= r_dbl_arm;
                  r_dbl_arm  <= 1'b0;
                  r_hold_cnt <= CNT_ONE;
                  r_held     <= 1'b1;
                  r_state    <= S_PRESSED;
               end else begin
                  r_gap_cnt  <= w_gap_inc;
                  if (w_gap_inc == DBL_LIM) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_state <= S_GAP;
                  end
               end
            end
`endif
            default: begin
               r_state <= S_IDLE;
               r_held  <= 1'b0;
            end
         endcase
      end
   end

   assign press_pulse   = r_press;
   assign release_pulse = r_release;
   assign long_pulse    = r_long;
   assign repeat_pulse  = r_repeat;
   assign held          = r_held;
   assign double_pulse  = r_double;

endmodule
